ram_fifo_ctrl: RTL and testbench

- FIFO controller that sits directly upstream of the single-port ram block and owns its ad/st/X pins.
- It turns the ram into a 2^ADDRESS_WIDTH-entry circular buffer with a valid/ready push side and a valid/ready pop side.
- The pop side has a one-entry output holding register, because ram read data (O) is combinational from ad and the single address port is shared between reads and writes.
- Total storage is 2^ADDRESS_WIDTH + 1 words.

---
 rtl/ram_fifo_ctrl.sv | 93 +++++++++
 tb/tb_ram_fifo_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/ram_fifo_ctrl.sv
// Circular-buffer FIFO controller that owns the pins of a single-port RAM.
// A one-word holding register on the pop side hides the combinational RAM read.
module ram_fifo_ctrl #(
   parameter int BUS_WIDTH     = 8,
   parameter int ADDRESS_WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [BUS_WIDTH-1:0]     in_data,
   input  logic                     in_valid,
   output logic                     in_ready,
   output logic [BUS_WIDTH-1:0]     out_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [ADDRESS_WIDTH-1:0] ram_ad,
   output logic                     ram_st,
   output logic [BUS_WIDTH-1:0]     ram_X,
   input  logic [BUS_WIDTH-1:0]     ram_O,
   output logic [ADDRESS_WIDTH:0]   mem_count
);

   localparam int DEPTH = 1 << ADDRESS_WIDTH;
   localparam logic [ADDRESS_WIDTH:0] DEPTH_C = (ADDRESS_WIDTH+1)'(DEPTH);

   // Handshakes: a transfer happens on the edge where valid && ready are both
   // high; in_ready never looks at in_valid, and out_valid is a flop.

   logic [ADDRESS_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDRESS_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDRESS_WIDTH:0]   mem_count_q, mem_count_d;
   logic [BUS_WIDTH-1:0]     out_data_q, out_data_d;
   logic                     out_valid_q, out_valid_d;

   logic prefetch;
   logic write;

   // Refilling the holding register wins the shared RAM port over a push.
   always_comb begin
      prefetch = (mem_count_q != '0) && (!out_valid_q || out_ready);
      in_ready = !rst && !prefetch && (mem_count_q != DEPTH_C);
      write    = in_valid && in_ready;
   end

   always_comb begin
      ram_ad = prefetch ? rd_ptr_q : wr_ptr_q;
      ram_st = write;
      ram_X  = in_data;
   end

   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      mem_count_d = mem_count_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;

      if (prefetch) begin
         out_data_d  = ram_O;
         out_valid_d = 1'b1;
         rd_ptr_d    = rd_ptr_q + ADDRESS_WIDTH'(1);
         mem_count_d = mem_count_q - (ADDRESS_WIDTH+1)'(1);
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end

      // write and prefetch are exclusive, so at most one count update applies
      if (write) begin
         wr_ptr_d    = wr_ptr_q + ADDRESS_WIDTH'(1);
         mem_count_d = mem_count_q + (ADDRESS_WIDTH+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         mem_count_q <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         mem_count_q <= mem_count_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign mem_count = mem_count_q;

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Directed bench for ram_fifo_ctrl with a behavioural single-port RAM and an
// expected-data queue checked on every pop handshake.
module tb_ram_fifo_ctrl;

   localparam int BW = 8;
   localparam int AW = 8;

   logic          clk;
   logic          rst;
   logic [BW-1:0] in_data;
   logic          in_valid;
   logic          in_ready;
   logic [BW-1:0] out_data;
   logic          out_valid;
   logic          out_ready;
   logic [AW-1:0] ram_ad;
   logic          ram_st;
   logic [BW-1:0] ram_X;
   logic [BW-1:0] ram_O;
   logic [AW:0]   mem_count;

   logic [BW-1:0] mem [1<<AW];
   logic [BW-1:0] exp_q[$];

   int total = 0;
   int bad   = 0;
   int n_push;
   int n_pop;

   ram_fifo_ctrl #(.BUS_WIDTH(BW), .ADDRESS_WIDTH(AW)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .ram_ad    (ram_ad),
      .ram_st    (ram_st),
      .ram_X     (ram_X),
      .ram_O     (ram_O),
      .mem_count (mem_count)
   );

   // clock / reset block and RAM model
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      for (int i = 0; i < (1<<AW); i++) mem[i] = '0;
   end
   assign ram_O = mem[ram_ad];
   always @(posedge clk) if (ram_st) mem[ram_ad] <= ram_X;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // one clock: record handshakes just before the edge, then sample #1 after it
   task automatic cyc();
      logic [BW-1:0] e;
      #1;
      if (in_valid === 1'b1 && in_ready === 1'b1) begin
         exp_q.push_back(in_data);
         n_push++;
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
         n_pop++;
         e = (exp_q.size() != 0) ? exp_q.pop_front() : ~out_data;
         chk("pop_data", {24'd0, out_data}, {24'd0, e});
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      cyc();
      rst = 1'b0;
      exp_q.delete();
      n_push = 0;
      n_pop  = 0;
   endtask

   initial begin
      n_push = 0; n_pop = 0;
      rst = 1'b1; in_valid = 1'b1; in_data = 8'h11; out_ready = 1'b0;

      // reset held for two edges with a push pending
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         chk("rst_in_ready",  {31'd0, in_ready},  32'd0);
         chk("rst_ram_st",    {31'd0, ram_st},    32'd0);
         chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
         chk("rst_out_data",  {24'd0, out_data},  32'd0);
         chk("rst_mem_count", {23'd0, mem_count}, 32'd0);
      end
      rst = 1'b0;
      #1 chk("rel_in_ready", {31'd0, in_ready}, 32'd1);
      cyc();
      chk("rel_mem_count", {23'd0, mem_count}, 32'd1);

      // latency of a single word
      do_reset();
      in_valid = 1'b1; in_data = 8'h5A; out_ready = 1'b1;
      #1;
      chk("lat_st",       {31'd0, ram_st},   32'd1);
      chk("lat_ad_push",  {24'd0, ram_ad},   32'd0);
      chk("lat_in_ready", {31'd0, in_ready}, 32'd1);
      cyc();
      in_valid = 1'b0;
      #1;
      chk("lat_ad_pref",   {24'd0, ram_ad},    32'd0);
      chk("lat_pref_rdy",  {31'd0, in_ready},  32'd0);
      chk("lat_mc1",       {23'd0, mem_count}, 32'd1);
      chk("lat_ov_early",  {31'd0, out_valid}, 32'd0);
      cyc();
      chk("lat_ov",   {31'd0, out_valid}, 32'd1);
      chk("lat_data", {24'd0, out_data},  32'h5A);
      chk("lat_mc0",  {23'd0, mem_count}, 32'd0);
      cyc();
      chk("lat_ov_fall", {31'd0, out_valid}, 32'd0);

      // fill to full with the consumer stalled
      do_reset();
      in_valid = 1'b1;
      for (int i = 0; i < 400; i++) begin
         in_data = n_push[BW-1:0];
         cyc();
      end
      chk("full_accepted", n_push, 32'd257);
      chk("full_in_ready", {31'd0, in_ready},  32'd0);
      chk("full_mc",       {23'd0, mem_count}, 32'd256);
      chk("full_ov",       {31'd0, out_valid}, 32'd1);
      chk("full_head",     {24'd0, out_data},  32'd0);
      in_valid = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < 600 && exp_q.size() != 0; i++) cyc();
      chk("full_drained", exp_q.size(), 32'd0);
      chk("full_pops",    n_pop, 32'd257);
      cyc();
      chk("drain_ov", {31'd0, out_valid}, 32'd0);
      chk("drain_mc", {23'd0, mem_count}, 32'd0);

      // random toggling across several pointer wraps
      do_reset();
      for (int i = 0; i < 8000 && n_pop < 600; i++) begin
         in_valid  = (n_push < 600) ? 1'($urandom_range(0, 1)) : 1'b0;
         out_ready = 1'($urandom_range(0, 1));
         in_data   = 8'($urandom_range(0, 255));
         cyc();
         chk("wrap_mc_le", {31'd0, (mem_count <= 9'd256)}, 32'd1);
      end
      chk("wrap_pops",  n_pop, 32'd600);
      chk("wrap_empty", exp_q.size(), 32'd0);

      // prefetch beats a pending push until memory is empty
      do_reset();
      in_valid = 1'b1;
      for (int i = 0; i < 20 && n_push < 4; i++) begin
         in_data = 8'hA0 + n_push[BW-1:0];
         cyc();
      end
      chk("cont_mc3", {23'd0, mem_count}, 32'd3);
      chk("cont_ov",  {31'd0, out_valid}, 32'd1);
      in_data = 8'hEE; out_ready = 1'b1;
      for (int i = 0; i < 10 && mem_count != 0; i++) begin
         #1;
         chk("cont_blocked", {31'd0, in_ready}, 32'd0);
         chk("cont_no_st",   {31'd0, ram_st},   32'd0);
         cyc();
      end
      chk("cont_mc0", {23'd0, mem_count}, 32'd0);
      #1 chk("cont_accept", {31'd0, in_ready}, 32'd1);
      cyc();
      in_valid = 1'b0;
      for (int i = 0; i < 10 && exp_q.size() != 0; i++) cyc();
      chk("cont_pushes", n_push, 32'd5);
      chk("cont_pops",   n_pop,  32'd5);

      // reset in the middle of traffic
      do_reset();
      in_valid = 1'b1;
      for (int i = 0; i < 30 && n_push < 11; i++) begin
         in_data = 8'h30 + n_push[BW-1:0];
         cyc();
      end
      in_valid = 1'b0;
      chk("mid_mc10", {23'd0, mem_count}, 32'd10);
      chk("mid_ov",   {31'd0, out_valid}, 32'd1);
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      exp_q.delete();
      chk("mid_ov0", {31'd0, out_valid}, 32'd0);
      chk("mid_mc0", {23'd0, mem_count}, 32'd0);
      in_valid = 1'b1; in_data = 8'hC3; out_ready = 1'b1;
      cyc();
      in_valid = 1'b0;
      cyc();
      chk("mid_first_ov",   {31'd0, out_valid}, 32'd1);
      chk("mid_first_data", {24'd0, out_data},  32'hC3);
      cyc();
      chk("mid_done", exp_q.size(), 32'd0);

      // final report
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
